freelist_ckpt: RTL and testbench
================================

# freelist_ckpt

Parametrised physical-register free list for the rename stage: a circular buffer of free physical register numbers with multi-lane in-order allocation (pop) and multi-lane release at commit (push). Adds per-branch checkpoints of the allocation pointer, so a mispredict returns every register allocated since the branch in one cycle. It replaces the fixed-width DISPATCH_WIDTH free list between rename (pop side) and commit (push side).

## Interface

- `PHYS_REGS`, 64: number of physical registers.
- `ARCH_REGS`, 32: architectural registers, mapped at reset and never in the list at reset.
- `POP_WIDTH`, 2: allocation lanes.
- `PUSH_WIDTH`, 2: release lanes.
- `NUM_CKPT`, 4: checkpoint slots.
- Derived values:
  - `DEPTH = PHYS_REGS-ARCH_REGS`; must be a power of two.
  - `AW = $clog2(PHYS_REGS)`.
  - `PW = $clog2(DEPTH)+1` (pointer plus wrap bit).

Ports:

- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `pop_en[POP_WIDTH]` in 1 each: allocate on lane i.
- `pop_reg[POP_WIDTH]` out AW each: register offered on lane i.
- `push_en[PUSH_WIDTH]` in 1 each: release on lane i.
- `push_reg[PUSH_WIDTH]` in AW each: register released on lane i.
- `ckpt_save` in 1: take a snapshot into slot `ckpt_id`.
- `ckpt_restore` in 1: roll back to slot `ckpt_id`.
- `ckpt_id` in $clog2(NUM_CKPT): slot select.
- `free_count` out PW: number of free entries.
- `full` out 1: `free_count==DEPTH`.
- `empty` out 1: `free_count==0`.
- `pop_ready` out 1: `free_count>=POP_WIDTH`.
- `underflow` out 1: one-cycle pulse when a pop request is rejected.
- `overflow` out 1: one-cycle pulse when a push request is rejected.

## Operation

- State:
  - storage `mem[DEPTH]` of AW bits;
  - `head` and `tail` of PW bits each;
  - `ckpt_head[NUM_CKPT]` of PW bits each.
- `free_count = tail - head` (PW-bit modular), registered from pointers.
- Reset state:
  - `mem[i] = ARCH_REGS+i`;
  - `head = 0`;
  - `tail = DEPTH` (wrap bit set, index 0);
  - all `ckpt_head = 0`.
- Reset output values:
  - `free_count = DEPTH`, `full = 1`, `empty = 0`;
  - `pop_ready = 1` when `DEPTH>=POP_WIDTH`;
  - `underflow = 0`, `overflow = 0`.
- Pop:
  - `pop_reg[i] = mem[(head+i) mod DEPTH]`, combinational.
  - Enabled lanes must be contiguous from lane 0. With n lanes enabled, head advances by n.
  - If `n > free_count`, the whole group is rejected: head is unchanged and `underflow` pulses.
- Push:
  - Enabled lanes are compacted in lane order. Lane i with k enabled lanes below it writes `mem[(tail+k) mod DEPTH]`; tail then advances by the enabled count m.
  - If `free_count + m > DEPTH`, the whole group is rejected: no write and `overflow` pulses.
  - Push values are not range-checked.
- Checkpoint save (`ckpt_save`): `ckpt_head[ckpt_id]` takes the head value after this cycle's accepted pops, so the branch's own group allocation is kept on rollback.
- Checkpoint restore (`ckpt_restore`):
  - `head` takes `ckpt_head[ckpt_id]`.
  - Pops in the same cycle are ignored: no advance and no `underflow`.
  - Pushes in the same cycle are still applied, because commits are older than the branch.
- Save and restore in the same cycle: restore takes effect; save is ignored.
- Checkpoint slots are not cleared on restore. Slot validity is owned by the branch tracker.

## Timing

- Pop data appears in the same cycle; head updates at the next edge. `pop_reg` for the next group is valid one cycle later.
- Pushed registers can be popped from the cycle after the push edge. There is no same-cycle bypass, so push-to-pop latency is 1.
- The counts used for the reject checks are the current-cycle `free_count`. A push in the same cycle does not rescue a pop.
- Restore latency is 1 cycle: `free_count` and `pop_reg` reflect the rolled-back head in the next cycle.
- Wrap-around: the pointer index wraps modulo DEPTH and the wrap bit toggles. When `free_count = DEPTH`, `full = 1` (head/tail same index, differing wrap bit).
- `rst` asserted mid-operation: all state returns to reset values immediately (asynchronously). Any in-flight pop/push in that cycle is lost.

## Configuration

- `FREELIST_CKPT_EN` defined: the checkpoint slots and the restore path are built as described.
- `FREELIST_CKPT_EN` not defined:
  - no `ckpt_head` storage is built;
  - `ckpt_save`, `ckpt_restore` and `ckpt_id` are present but ignored;
  - head moves only on pops.
  - Recovery is then the rename unit's job, by replaying pushes.

## Test plan

- Reset (defaults) → `free_count=32`, `full=1`, `empty=0`, `pop_reg[0]=32`, `pop_reg[1]=33`.
- Pop 2 lanes for 16 cycles → registers 32..63 issued in order, then `free_count=0`, `empty=1`, `pop_ready=0`. A further pop → `underflow` pulses and head is unchanged.
- From full, push 1 → `overflow` pulses and `free_count` stays 32. After popping 2, push 40 and 41 → they appear at `pop_reg` after wrap-around, following register 63.
- Pop 32,33 with `ckpt_save` id=1; pop 34..37; `ckpt_restore` id=1 → next cycle `pop_reg[0]=34`, `free_count=30`.
- Restore together with 2 pops and a push of reg 5 → pops ignored, register 5 queued, `free_count` = restored value + 1.
- Assert `rst` after 10 pops → outputs return immediately to reset values. Build without `FREELIST_CKPT_EN`: restore has no effect.

Source files
------------

// File: rtl/freelist_ckpt.sv
// Rename free list: circular buffer of free physical regs, multi-lane pop/push, head checkpoints under FREELIST_CKPT_EN.
// Latency: pop_reg is combinational from head; pointers, free_count and the reject pulses follow the next rising edge.
// Backpressure: an oversize pop group or overfilling push group is dropped whole and flagged by underflow/overflow the next cycle.
module freelist_ckpt #(
  parameter int PHYS_REGS  = 64,
  parameter int ARCH_REGS  = 32,
  parameter int POP_WIDTH  = 2,
  parameter int PUSH_WIDTH = 2,
  parameter int NUM_CKPT   = 4,
  localparam int DEPTH     = PHYS_REGS - ARCH_REGS,
  localparam int AW        = $clog2(PHYS_REGS),
  localparam int PW        = $clog2(DEPTH) + 1,
  localparam int CW        = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [POP_WIDTH-1:0]  pop_en,
  output logic [AW-1:0]         pop_reg [POP_WIDTH],
  input  logic [PUSH_WIDTH-1:0] push_en,
  input  logic [AW-1:0]         push_reg [PUSH_WIDTH],
  input  logic                  ckpt_save,
  input  logic                  ckpt_restore,
  input  logic [CW-1:0]         ckpt_id,
  output logic [PW-1:0]         free_count,
  output logic                  full,
  output logic                  empty,
  output logic                  pop_ready,
  output logic                  underflow,
  output logic                  overflow
);
  localparam int IW   = PW - 1;   // slot index width, pointers carry one extra wrap bit
  localparam int CNTW = PW + 1;   // room for free_count + push count without wrapping

  logic [AW-1:0]   mem [DEPTH];
  logic [PW-1:0]   head, tail;
  logic [PW-1:0]   head_pop, head_nxt, tail_nxt;
  logic [PW-1:0]   restore_head;
  logic [CNTW-1:0] pop_n, push_m;
  logic [IW-1:0]   push_idx [PUSH_WIDTH];
  logic            pop_rej, push_rej, restore_act;

  assign free_count = tail - head;
  assign full       = (free_count == PW'(DEPTH));
  assign empty      = (free_count == '0);
  assign pop_ready  = ({1'b0, free_count} >= CNTW'(POP_WIDTH));

  for (genvar g = 0; g < POP_WIDTH; g++) begin : g_pop
    assign pop_reg[g] = mem[head[IW-1:0] + IW'(g)];
  end

`ifdef FREELIST_CKPT_EN
  logic [PW-1:0] ckpt_head [NUM_CKPT];

  assign restore_act  = ckpt_restore;
  assign restore_head = ckpt_head[ckpt_id];

  // Snapshot the post-pop head so the branch keeps its own group on rollback; a same-cycle restore wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CKPT; i++) ckpt_head[i] <= '0;
    end else if (ckpt_save && !ckpt_restore) begin
      ckpt_head[ckpt_id] <= head_pop;
    end
  end
`else
  logic ckpt_unused;

  // Without checkpoints the rename unit recovers by replaying pushes; the ports stay for pin compatibility.
  assign restore_act  = 1'b0;
  assign restore_head = '0;
  assign ckpt_unused  = ^{ckpt_save, ckpt_restore, ckpt_id};
`endif

  // Lane counts, compacted push slots and whole-group reject decisions from the current free_count.
  always_comb begin
    pop_n = '0;
    for (int i = 0; i < POP_WIDTH; i++) pop_n = pop_n + CNTW'(pop_en[i]);
    push_m = '0;
    for (int i = 0; i < PUSH_WIDTH; i++) begin
      push_idx[i] = tail[IW-1:0] + push_m[IW-1:0];
      push_m      = push_m + CNTW'(push_en[i]);
    end
    pop_rej  = (pop_n > {1'b0, free_count});
    push_rej = (({1'b0, free_count} + push_m) > CNTW'(DEPTH));
    // A restore discards this cycle's pops; commits (pushes) are older than the branch and still land.
    head_pop = (restore_act || pop_rej) ? head : head + pop_n[PW-1:0];
    head_nxt = restore_act ? restore_head : head_pop;
    tail_nxt = push_rej ? tail : tail + push_m[PW-1:0];
  end

  // Pointer and reject-pulse registers; reset starts with every non-architectural reg free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head      <= '0;
      tail      <= PW'(DEPTH);
      underflow <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      head      <= head_nxt;
      tail      <= tail_nxt;
      underflow <= pop_rej && !restore_act;
      overflow  <= push_rej;
    end
  end

  // Storage: reset to ARCH_REGS.. in order, accepted pushes written compacted from tail.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= AW'(ARCH_REGS + i);
    end else if (!push_rej) begin
      for (int i = 0; i < PUSH_WIDTH; i++) begin
        if (push_en[i]) mem[push_idx[i]] <= push_reg[i];
      end
    end
  end

endmodule

// File: tb/tb_freelist_ckpt.sv
// Bench for freelist_ckpt: directed vector table, checkpoint and async-reset sequences,
// then random traffic against a sequence-number model of the free list.
// Expectations for restore depend on whether FREELIST_CKPT_EN is defined for the build.
module tb_freelist_ckpt;
  localparam int DEPTH = 32;
  localparam int AW    = 6;
  localparam int PW    = 6;
`ifdef FREELIST_CKPT_EN
  localparam bit CKPT = 1'b1;
`else
  localparam bit CKPT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    pop_en, push_en;
  logic [AW-1:0] pop_reg [2];
  logic [AW-1:0] push_reg [2];
  logic          ckpt_save, ckpt_restore;
  logic [1:0]    ckpt_id;
  logic [PW-1:0] free_count;
  logic          full, empty, pop_ready, underflow, overflow;

  int nvec = 0;
  int nmis = 0;

  freelist_ckpt dut (
    .clk(clk), .rst(rst),
    .pop_en(pop_en), .pop_reg(pop_reg),
    .push_en(push_en), .push_reg(push_reg),
    .ckpt_save(ckpt_save), .ckpt_restore(ckpt_restore), .ckpt_id(ckpt_id),
    .free_count(free_count), .full(full), .empty(empty), .pop_ready(pop_ready),
    .underflow(underflow), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int         n;
    logic [1:0] pe;
    int         r0, r1;
    int         f, p0, p1;
    bit         uf, of;
  } vec_t;

  vec_t tbl[$];

  // Model: every free-list entry gets an absolute sequence number; head/tail never wrap.
  int slot[int];
  int head_a, tail_a;
  int ck[4];
  bit ckv[4];
  bit e_uf, e_of;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_state(input string tag, input int f, input int p0, input int p1,
                           input bit uf, input bit of);
    chk({tag, " free_count"}, 32'(free_count), f);
    chk({tag, " full"}, 32'(full), 32'(f == DEPTH));
    chk({tag, " empty"}, 32'(empty), 32'(f == 0));
    chk({tag, " pop_ready"}, 32'(pop_ready), 32'(f >= 2));
    if (p0 >= 0) chk({tag, " pop_reg0"}, 32'(pop_reg[0]), p0);
    if (p1 >= 0) chk({tag, " pop_reg1"}, 32'(pop_reg[1]), p1);
    chk({tag, " underflow"}, 32'(underflow), 32'(uf));
    chk({tag, " overflow"}, 32'(overflow), 32'(of));
  endtask

  task automatic idle();
    pop_en = 2'b00; push_en = 2'b00;
    push_reg[0] = '0; push_reg[1] = '0;
    ckpt_save = 1'b0; ckpt_restore = 1'b0; ckpt_id = 2'd0;
  endtask

  task automatic set_in(input int n, input logic [1:0] pe, input int r0, input int r1,
                        input bit sv, input bit rs, input int id);
    pop_en = 2'((1 << n) - 1);
    push_en = pe;
    push_reg[0] = AW'(r0); push_reg[1] = AW'(r1);
    ckpt_save = sv; ckpt_restore = rs; ckpt_id = 2'(id);
  endtask

  task automatic drive(input int n, input logic [1:0] pe, input int r0, input int r1,
                       input bit sv, input bit rs, input int id);
    set_in(n, pe, r0, r1, sv, rs, id);
    @(posedge clk); #1;
    idle();
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic add(input int n, input logic [1:0] pe, input int r0, input int r1,
                     input int f, input int p0, input int p1, input bit uf, input bit of);
    vec_t v;
    v.n = n; v.pe = pe; v.r0 = r0; v.r1 = r1;
    v.f = f; v.p0 = p0; v.p1 = p1; v.uf = uf; v.of = of;
    tbl.push_back(v);
  endtask

  task automatic model_reset();
    slot.delete();
    for (int i = 0; i < DEPTH; i++) slot[i] = 32 + i;
    head_a = 0; tail_a = DEPTH;
    for (int i = 0; i < 4; i++) begin ck[i] = 0; ckv[i] = 1'b1; end
    e_uf = 1'b0; e_of = 1'b0;
  endtask

  initial begin
    int n, m, id, fr;
    logic [1:0] pe;
    int r0, r1;
    bit sv, rs;

    idle();
    rst = 1'b1;
    do_reset();
    chk_state("reset", 32, 32, 33, 1'b0, 1'b0);

    // Directed table, outputs checked after each edge (pop_reg from the new head).
    add(0, 2'b01, 1, 0,   32, 32, 33, 0, 1);   // push into a full list
    add(2, 2'b00, 0, 0,   30, 34, 35, 0, 0);
    add(0, 2'b11, 40, 41, 32, 34, 35, 0, 0);   // refill slots 0,1 with 40,41
    add(0, 2'b10, 0, 1,   32, 34, 35, 0, 1);   // lane-1-only push while full
    for (int j = 1; j <= 15; j++) begin
      int h;
      h = (2 + 2 * j) % 32;
      add(2, 2'b00, 0, 0, 32 - 2 * j, (h == 0) ? 40 : 32 + h, (h == 0) ? 41 : 33 + h, 0, 0);
    end
    add(2, 2'b00, 0, 0,   0, 34, 35, 0, 0);    // drains to empty
    add(2, 2'b10, 0, 7,   1, 7, 35, 1, 0);     // push does not rescue pop; lane 1 compacted
    add(2, 2'b00, 0, 0,   1, 7, 35, 1, 0);
    add(1, 2'b00, 0, 0,   0, 35, 36, 0, 0);
    add(0, 2'b00, 0, 0,   0, 35, 36, 0, 0);
    add(0, 2'b11, 9, 10,  2, 9, 10, 0, 0);
    add(2, 2'b01, 11, 0,  1, 11, 38, 0, 0);    // simultaneous pop and push
    foreach (tbl[k]) begin
      drive(tbl[k].n, tbl[k].pe, tbl[k].r0, tbl[k].r1, 1'b0, 1'b0, 0);
      chk_state($sformatf("vec%0d", k), tbl[k].f, tbl[k].p0, tbl[k].p1, tbl[k].uf, tbl[k].of);
    end

    // Checkpoint save/restore sequence.
    do_reset();
    drive(2, 2'b00, 0, 0, 1'b1, 1'b0, 1);
    chk_state("ck save1", 30, 34, 35, 0, 0);
    drive(2, 2'b00, 0, 0, 1'b1, 1'b0, 3);
    chk_state("ck save3", 28, 36, 37, 0, 0);
    drive(2, 2'b00, 0, 0, 1'b0, 1'b0, 0);
    chk_state("ck pop", 26, 38, 39, 0, 0);
    drive(0, 2'b00, 0, 0, 1'b0, 1'b1, 1);
    chk_state("ck restore1", CKPT ? 30 : 26, CKPT ? 34 : 38, CKPT ? 35 : 39, 0, 0);
    drive(2, 2'b01, 5, 0, 1'b0, 1'b1, 1);
    chk_state("ck restore+pop+push", CKPT ? 31 : 25, CKPT ? 34 : 40, CKPT ? 35 : 41, 0, 0);
    drive(0, 2'b00, 0, 0, 1'b1, 1'b1, 3);
    chk_state("ck save+restore3", CKPT ? 29 : 25, CKPT ? 36 : 40, CKPT ? 37 : 41, 0, 0);
    drive(2, 2'b00, 0, 0, 1'b0, 1'b0, 0);
    chk_state("ck pop2", CKPT ? 27 : 23, CKPT ? 38 : 42, CKPT ? 39 : 43, 0, 0);
    drive(0, 2'b00, 0, 0, 1'b0, 1'b1, 3);
    chk_state("ck restore3 again", CKPT ? 29 : 23, CKPT ? 36 : 42, CKPT ? 37 : 43, 0, 0);

    // Asynchronous reset in the middle of traffic.
    do_reset();
    for (int j = 0; j < 5; j++) drive(2, 2'b00, 0, 0, 1'b0, 1'b0, 0);
    drive(0, 2'b11, 1, 2, 1'b0, 1'b0, 0);
    chk_state("pre-rst", 24, 42, 43, 0, 0);
    rst = 1'b1;
    #1;
    chk_state("async rst", 32, 32, 33, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Random traffic against the sequence-number model.
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      fr = tail_a - head_a;
      chk_state("rnd", fr, -1, -1, e_uf, e_of);
      for (int i = 0; i < 2; i++)
        if (i < fr) chk($sformatf("rnd pop_reg%0d", i), 32'(pop_reg[i]), slot[head_a + i]);

      if (((c / 150) % 2) == 0) begin
        n = $urandom_range(1, 2);
        pe[0] = ($urandom_range(0, 2) == 0); pe[1] = ($urandom_range(0, 2) == 0);
      end else begin
        n = $urandom_range(0, 1);
        pe[0] = ($urandom_range(0, 2) != 0); pe[1] = ($urandom_range(0, 2) != 0);
      end
      m  = int'(pe[0]) + int'(pe[1]);
      r0 = $urandom_range(0, 63); r1 = $urandom_range(0, 63);
      sv = ($urandom_range(0, 5) == 0);
      id = $urandom_range(0, 3);
      rs = 1'b0;
      if ($urandom_range(0, 7) == 0) begin
        if (!CKPT) rs = 1'b1;
        else if (ckv[id] && (tail_a + m - ck[id] <= DEPTH)) rs = 1'b1;
      end
      set_in(n, pe, r0, r1, sv, rs, id);
      @(posedge clk);

      e_uf = 1'b0; e_of = 1'b0;
      if (!(CKPT && rs)) begin
        if (n > fr) e_uf = 1'b1;
        else head_a += n;
      end
      if (fr + m > DEPTH) e_of = 1'b1;
      else begin
        if (pe[0]) begin slot[tail_a] = r0; tail_a++; end
        if (pe[1]) begin slot[tail_a] = r1; tail_a++; end
      end
      if (CKPT && sv && !rs) begin ck[id] = head_a; ckv[id] = 1'b1; end
      if (CKPT && rs) head_a = ck[id];
      for (int s = 0; s < 4; s++) if (tail_a - ck[s] > DEPTH) ckv[s] = 1'b0;
      #1;
      idle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
